dtmf_tone_gen: RTL and testbench



---
 rtl/dtmf_tone_gen.sv | 196 +++++++++++++++++++
 tb/tb_dtmf_tone_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtmf_tone_gen.sv
// DTMF keypad tone generator: synchronizes and debounces a key press,
// then plays the row/column square-wave pair followed by a silent gap.
module dtmf_tone_gen #(
    parameter int CLK_HZ       = 12000000,
    parameter int DEBOUNCE_CYC = 120000,
    parameter int MIN_TONE_CYC = 480000,
    parameter int GAP_CYC      = 480000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       key_down,
    output logic       tone_low,
    output logic       tone_high,
    output logic [1:0] tone_mix,
    output logic       busy,
    output logic       tone_start,
    output logic [3:0] key_latched
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        TONE,
        GAP
    } state_t;

    function automatic int hp(input int f);
        return (CLK_HZ + f) / (2 * f);
    endfunction

    localparam int HP_L0 = hp(697);
    localparam int HP_L1 = hp(770);
    localparam int HP_L2 = hp(852);
    localparam int HP_L3 = hp(941);
    localparam int HP_H0 = hp(1209);
    localparam int HP_H1 = hp(1336);
    localparam int HP_H2 = hp(1477);
    localparam int HP_H3 = hp(1633);

    // 697 Hz is the lowest frequency, so it has the longest half-period
    localparam int HW = $clog2(HP_L0 + 1);
    localparam int DW = $clog2(MIN_TONE_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int BW = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [DW-1:0] DUR_MAX  = DW'(MIN_TONE_CYC);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    // the IDLE sample that enters DEBOUNCE is the first accepted one
    localparam logic [BW-1:0] DB_LAST  =
        BW'((DEBOUNCE_CYC >= 2) ? DEBOUNCE_CYC - 2 : 0);

    state_t        state;
    logic          kd_s1;
    logic          kd_s;
    logic [BW-1:0] db_cnt;
    logic [DW-1:0] dur_cnt;
    logic [DW-1:0] dur_inc;
    logic [GW-1:0] gap_cnt;
    logic [HW-1:0] lo_cnt;
    logic [HW-1:0] hi_cnt;
    logic [HW-1:0] lo_top;
    logic [HW-1:0] hi_top;
    logic [1:0]    row;
    logic [1:0]    col;

    // two-flop synchronizer for the asynchronous key_down level
    always_ff @(posedge clk) begin
        if (reset) begin
            kd_s1 <= 1'b0;
            kd_s  <= 1'b0;
        end else begin
            kd_s1 <= key_down;
            kd_s  <= kd_s1;
        end
    end

    // keypad code to (row, column) group
    always_comb begin
        row = 2'd0;
        col = 2'd0;
        unique case (key_latched)
            4'h1: begin row = 2'd0; col = 2'd0; end
            4'h2: begin row = 2'd0; col = 2'd1; end
            4'h3: begin row = 2'd0; col = 2'd2; end
            4'hA: begin row = 2'd0; col = 2'd3; end
            4'h4: begin row = 2'd1; col = 2'd0; end
            4'h5: begin row = 2'd1; col = 2'd1; end
            4'h6: begin row = 2'd1; col = 2'd2; end
            4'hB: begin row = 2'd1; col = 2'd3; end
            4'h7: begin row = 2'd2; col = 2'd0; end
            4'h8: begin row = 2'd2; col = 2'd1; end
            4'h9: begin row = 2'd2; col = 2'd2; end
            4'hC: begin row = 2'd2; col = 2'd3; end
            4'hE: begin row = 2'd3; col = 2'd0; end
            4'h0: begin row = 2'd3; col = 2'd1; end
            4'hF: begin row = 2'd3; col = 2'd2; end
            4'hD: begin row = 2'd3; col = 2'd3; end
        endcase
    end

    // wrap points of the two wave counters for the latched key
    always_comb begin
        lo_top = HW'(HP_L0 - 1);
        hi_top = HW'(HP_H0 - 1);
        unique case (row)
            2'd0: lo_top = HW'(HP_L0 - 1);
            2'd1: lo_top = HW'(HP_L1 - 1);
            2'd2: lo_top = HW'(HP_L2 - 1);
            2'd3: lo_top = HW'(HP_L3 - 1);
        endcase
        unique case (col)
            2'd0: hi_top = HW'(HP_H0 - 1);
            2'd1: hi_top = HW'(HP_H1 - 1);
            2'd2: hi_top = HW'(HP_H2 - 1);
            2'd3: hi_top = HW'(HP_H3 - 1);
        endcase
    end

    assign dur_inc  = (dur_cnt == DUR_MAX) ? dur_cnt : dur_cnt + 1'b1;
    assign tone_mix = {1'b0, tone_low} + {1'b0, tone_high};

    // main FSM with registered outputs and all tone/duration counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            db_cnt      <= '0;
            dur_cnt     <= '0;
            gap_cnt     <= '0;
            lo_cnt      <= '0;
            hi_cnt      <= '0;
            tone_low    <= 1'b0;
            tone_high   <= 1'b0;
            busy        <= 1'b0;
            tone_start  <= 1'b0;
            key_latched <= 4'h0;
        end else begin
            tone_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (kd_s) begin
                        state  <= DEBOUNCE;
                        db_cnt <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (!kd_s) begin
                        state <= IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= TONE;
                        key_latched <= key;
                        tone_start  <= 1'b1;
                        busy        <= 1'b1;
                        lo_cnt      <= '0;
                        hi_cnt      <= '0;
                        dur_cnt     <= '0;
                        tone_low    <= 1'b0;
                        tone_high   <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                TONE: begin
                    dur_cnt <= dur_inc;
                    if (lo_cnt == lo_top) begin
                        lo_cnt   <= '0;
                        tone_low <= ~tone_low;
                    end else begin
                        lo_cnt <= lo_cnt + 1'b1;
                    end
                    if (hi_cnt == hi_top) begin
                        hi_cnt    <= '0;
                        tone_high <= ~tone_high;
                    end else begin
                        hi_cnt <= hi_cnt + 1'b1;
                    end
                    if (dur_inc == DUR_MAX && !kd_s) begin
                        state     <= GAP;
                        gap_cnt   <= '0;
                        tone_low  <= 1'b0;
                        tone_high <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtmf_tone_gen.sv
// Bench for dtmf_tone_gen: directed scenarios plus random key activity,
// compared every cycle against a timeline model of the tone generator.
module tb_dtmf_tone_gen;

    localparam int CLKHZ = 40000;
    localparam int DEB   = 4;
    localparam int MINT  = 64;
    localparam int GAPC  = 8;

    logic       clk;
    logic       reset;
    logic [3:0] key;
    logic       key_down;
    logic       tone_low;
    logic       tone_high;
    logic [1:0] tone_mix;
    logic       busy;
    logic       tone_start;
    logic [3:0] key_latched;

    dtmf_tone_gen #(
        .CLK_HZ(CLKHZ),
        .DEBOUNCE_CYC(DEB),
        .MIN_TONE_CYC(MINT),
        .GAP_CYC(GAPC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key(key),
        .key_down(key_down),
        .tone_low(tone_low),
        .tone_high(tone_high),
        .tone_mix(tone_mix),
        .busy(busy),
        .tone_start(tone_start),
        .key_latched(key_latched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    function automatic int hp_of(input int hz, input int f);
        real r;
        r = hz / (2.0 * f);
        return $rtoi(r + 0.5);
    endfunction

    // keypad layout: row and column of each key code 0..F
    int ROWS [16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
    int COLS [16] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 0, 2};
    int LOWF [4]  = '{697, 770, 852, 941};
    int HIGHF[4]  = '{1209, 1336, 1477, 1633};

    // timeline model: a tone starts once DEB consecutive synced-high
    // samples are seen while silent, lasts until released and at least
    // MINT cycles old, then GAPC silent busy cycles follow
    bit         m_valid = 0;
    bit         m_tone, m_gap;
    int         m_t0, m_g0, run;
    logic       kd1, kd2, s2;
    logic [3:0] m_key;
    logic [9:0] exp_vec;

    // measurement for the directed scenarios
    int ts_count, busy_count, ts_time;
    int lo_tog[$];
    int hi_tog[$];
    logic prev_lo, prev_hi;

    always @(posedge clk) begin
        int n, k, lo, hi, st;
        n = cyc + 1;
        st = 0;
        if (reset) begin
            m_valid = 1;
            m_tone = 0;
            m_gap = 0;
            run = 0;
            m_key = 4'h0;
            kd1 = 1'b0;
            kd2 = 1'b0;
        end else begin
            s2 = kd2;
            kd2 = kd1;
            kd1 = key_down;
            if (m_tone) begin
                if (n - m_t0 >= MINT && !s2) begin
                    m_tone = 0;
                    m_gap = 1;
                    m_g0 = n;
                end
            end else if (m_gap) begin
                if (n - m_g0 >= GAPC) m_gap = 0;
            end else begin
                run = s2 ? run + 1 : 0;
                if (run == DEB) begin
                    m_tone = 1;
                    m_t0 = n;
                    m_key = key;
                    run = 0;
                    st = 1;
                end
            end
        end
        lo = 0;
        hi = 0;
        if (m_tone) begin
            k = n - m_t0;
            lo = (k / hp_of(CLKHZ, LOWF[ROWS[m_key]])) % 2;
            hi = (k / hp_of(CLKHZ, HIGHF[COLS[m_key]])) % 2;
        end
        exp_vec = {lo[0], hi[0], 2'(lo + hi), m_tone | m_gap, st[0], m_key};
        #1;
        cyc++;
        if (m_valid)
            chk("outputs", {tone_low, tone_high, tone_mix, busy,
                            tone_start, key_latched}, exp_vec);
        if (tone_start) begin
            if (ts_count == 0) ts_time = cyc;
            ts_count++;
        end
        if (busy) busy_count++;
        if (tone_low !== prev_lo) lo_tog.push_back(cyc);
        if (tone_high !== prev_hi) hi_tog.push_back(cyc);
        prev_lo = tone_low;
        prev_hi = tone_high;
    end

    task automatic clear_meas();
        ts_count = 0;
        busy_count = 0;
        ts_time = 0;
        lo_tog.delete();
        hi_tog.delete();
        prev_lo = tone_low;
        prev_hi = tone_high;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k, input int len, output int rise);
        @(negedge clk);
        key = k;
        key_down = 1'b1;
        rise = cyc;
        repeat (len) @(negedge clk);
        key_down = 1'b0;
    endtask

    task automatic chk_toggles(input string nm, input int hpl, input int hph);
        chk({nm, "_lo_n"}, 32'(lo_tog.size() >= 2), 1);
        chk({nm, "_hi_n"}, 32'(hi_tog.size() >= 2), 1);
        if (lo_tog.size() >= 2) begin
            chk({nm, "_lo_first"}, lo_tog[0] - ts_time, hpl);
            chk({nm, "_lo_per"}, lo_tog[1] - lo_tog[0], hpl);
        end
        if (hi_tog.size() >= 2) begin
            chk({nm, "_hi_first"}, hi_tog[0] - ts_time, hph);
            chk({nm, "_hi_per"}, hi_tog[1] - hi_tog[0], hph);
        end
    endtask

    initial begin
        int rise, len;
        reset = 1'b1;
        key = 4'h0;
        key_down = 1'b0;
        idle(3);
        reset = 1'b0;

        // model pins at default clock rate
        chk("hp_697", hp_of(12000000, 697), 8608);
        chk("hp_770", hp_of(12000000, 770), 7792);
        chk("hp_1336", hp_of(12000000, 1336), 4491);
        chk("hp_1633", hp_of(12000000, 1633), 3674);

        chk("rst_vec", {tone_low, tone_high, tone_mix, busy,
                        tone_start, key_latched}, 0);

        // clean press of key 5
        clear_meas();
        press(4'h5, 100, rise);
        idle(100);
        chk("p5_starts", ts_count, 1);
        chk("p5_latency", ts_time - rise, 6);
        chk("p5_key", key_latched, 4'h5);
        chk_toggles("p5", 26, 15);

        // bouncing contact never reaches the debounce count
        clear_meas();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            key = 4'h3;
            key_down = 1'b1;
            idle(3);
            key_down = 1'b0;
        end
        idle(20);
        chk("bnc_starts", ts_count, 0);
        chk("bnc_busy", busy_count, 0);

        // short press: minimum tone then gap
        clear_meas();
        press(4'h8, 4, rise);
        idle(120);
        chk("sp_starts", ts_count, 1);
        chk("sp_busy", busy_count, MINT + GAPC);
        chk("sp_key", key_latched, 4'h8);

        // key changes while the tone plays
        clear_meas();
        @(negedge clk);
        key = 4'h1;
        key_down = 1'b1;
        idle(40);
        key = 4'hD;
        idle(110);
        key_down = 1'b0;
        idle(100);
        chk("kc_starts", ts_count, 1);
        chk("kc_key", key_latched, 4'h1);
        chk_toggles("kc", 29, 17);

        // held key with a one-cycle dip: second tone after the gap
        clear_meas();
        press(4'h7, 100, rise);
        @(negedge clk);
        key_down = 1'b1;
        idle(80);
        key_down = 1'b0;
        idle(100);
        chk("hold_starts", ts_count, 2);
        chk("hold_busy", busy_count, 182);

        // reset during a tone silences everything at once
        clear_meas();
        @(negedge clk);
        key = 4'h9;
        key_down = 1'b1;
        idle(30);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_vec", {tone_low, tone_high, tone_mix, busy,
                         tone_start, key_latched}, 0);
        key_down = 1'b0;
        idle(30);

        // random key activity with occasional resets
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            key = 4'($urandom);
            key_down = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 6);
            else len = $urandom_range(1, 90);
            idle(len);
        end
        key_down = 1'b0;
        idle(100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
